sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 25, SDRAM byte-address width.
REQ-002 Parameter: FIXED_PRIO, 0, 0 = round-robin, 1 = port 0 always wins.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 p0_valid, p1_valid  input  1 each  port request held until port ready.
REQ-006 p0_addr, p1_addr  input  ADDR_W each  byte address; bits [1:0] ignored.
REQ-007 p0_wdata, p1_wdata  input  32 each  write data.
REQ-008 p0_wstrb, p1_wstrb  input  4 each  byte enables; 0 = read.
REQ-009 p0_ready, p1_ready  output  1 each  one-cycle completion pulse.
REQ-010 p0_rdata, p1_rdata  output  32 each  registered read data, valid with ready pulse.
REQ-011 sd_valid  output  1  request to SDRAM controller.
REQ-012 sd_addr  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
REQ-013 sd_din, sd_wmask  output  32, 4  write data and mask to controller.
REQ-014 sd_ready, sd_dout  input  1, 32  controller completion flag and read data.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, RELEASE, DONE.
REQ-016 IDLE: if any port valid and sd_ready low, SHALL latch winner's addr/wdata/wstrb into sd_* registers, set sd_valid=1, record grant, go ISSUE.
REQ-017 IDLE with sd_ready high SHALL stay IDLE (controller not yet released).
REQ-018 ISSUE: on sd_ready=1 SHALL capture sd_dout into granted port's rdata (reads only), drive sd_valid=0, sd_wmask=0, go RELEASE.
REQ-019 RELEASE: on sd_ready=0 SHALL go DONE.
REQ-020 DONE: SHALL pulse granted port's ready for exactly one cycle, update last-grant pointer, go IDLE.
REQ-021 Non-granted port's ready SHALL stay 0; its rdata SHALL hold previous value.
REQ-022 Round-robin: both valid in IDLE -> grant port not served last; single valid -> grant it regardless of pointer.
REQ-023 FIXED_PRIO=1: both valid -> grant port 0.
REQ-024 Port request arriving during ISSUE/RELEASE/DONE SHALL wait; no preemption.
REQ-025 Winner's address/data SHALL be sampled only in IDLE; later port input changes SHALL not affect sd_* outputs.
REQ-026 Minimum latency port valid -> port ready = 3 cycles plus controller ready assertion/deassertion time.
REQ-027 A port holding valid after its ready pulse SHALL be treated as a new request in the following IDLE cycle.
REQ-028 Write transactions SHALL leave port rdata unchanged.

Reset
REQ-029 resetn=0 SHALL force, on next edge: state IDLE, sd_valid=0, sd_wmask=0, sd_addr=0, sd_din=0, p0_ready=p1_ready=0, p0_rdata=p1_rdata=0, last-grant pointer=port 1 (port 0 wins first tie).
REQ-030 Reset mid-transaction SHALL abandon it without any port ready pulse.
REQ-031 After reset release, first grant SHALL wait for sd_ready=0.

Verification
REQ-032 p0 read addr 0x0000104, p1 idle, controller model returns 0xDEADBEEF -> sd_addr=0x0000104, sd_wmask=0, p0_ready single pulse, p0_rdata=0xDEADBEEF, p1_ready never high.
REQ-033 p0 and p1 writes asserted same cycle, FIXED_PRIO=0, after reset -> p0 served first (wmask=p0_wstrb), then p1; pointer alternates on 4 back-to-back pairs (0,1,0,1,...).
REQ-034 FIXED_PRIO=1, both ports continuously valid -> all 4 grants to port 0; p1 starved; port 1 served only once p0 drops.
REQ-035 p1 write addr 0x0000207 wdata 0x12345678 wstrb 4'b0011 -> sd_addr=0x0000204, sd_din=0x12345678, sd_wmask=4'b0011 during ISSUE, sd_wmask=0 after sd_ready.
REQ-036 Controller holds sd_ready high 5 cycles after completion -> arbiter stays RELEASE, no ready pulse until sd_ready=0, no new sd_valid meanwhile.
REQ-037 resetn low during ISSUE -> next cycle sd_valid=0, all outputs at reset values, no port ready pulse; subsequent p0 read completes normally.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port arbiter in front of a single-request SDRAM controller handshake
module sdram_arbiter #(
  parameter int ADDR_W     = 25,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [3:0]        p0_wstrb,
  output logic              p0_ready,
  output logic [31:0]       p0_rdata,
  input  logic              p1_valid,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [3:0]        p1_wstrb,
  output logic              p1_ready,
  output logic [31:0]       p1_rdata,
  output logic              sd_valid,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [31:0]       sd_din,
  output logic [3:0]        sd_wmask,
  input  logic              sd_ready,
  input  logic [31:0]       sd_dout
);
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, DONE} state_t;
  state_t state, state_n;
  logic grant, last, pick, load, capture, rel, finish;
  // last == 1 after reset so port 0 wins the first tie
  assign pick = (p0_valid && p1_valid) ? (FIXED_PRIO ? 1'b0 : ~last) : p1_valid;
  always_comb begin
    state_n = state;
    load    = 1'b0;
    capture = 1'b0;
    rel     = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE:    if ((p0_valid || p1_valid) && !sd_ready) begin load = 1'b1; state_n = ISSUE; end
      ISSUE:   if (sd_ready) begin capture = 1'b1; state_n = RELEASE; end
      RELEASE: if (!sd_ready) begin rel = 1'b1; state_n = DONE; end
      DONE:    begin finish = 1'b1; state_n = IDLE; end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      grant    <= 1'b0;
      last     <= 1'b1;
      sd_valid <= 1'b0;
      sd_addr  <= '0;
      sd_din   <= '0;
      sd_wmask <= '0;
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      state    <= state_n;
      p0_ready <= rel && !grant;
      p1_ready <= rel && grant;
      if (load) begin
        grant    <= pick;
        sd_valid <= 1'b1;
        sd_addr  <= (pick ? p1_addr : p0_addr) & ~ADDR_W'(3);
        sd_din   <= pick ? p1_wdata : p0_wdata;
        sd_wmask <= pick ? p1_wstrb : p0_wstrb;
      end
      // an all-zero mask marks a read; only reads update the port's rdata
      if (capture) begin
        sd_valid <= 1'b0;
        sd_wmask <= '0;
        if (sd_wmask == 4'h0 && grant) p1_rdata <= sd_dout;
        if (sd_wmask == 4'h0 && !grant) p0_rdata <= sd_dout;
      end
      if (finish) last <= grant;
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: randomized scoreboard bench for sdram_arbiter (round-robin) plus a fixed-priority instance
module tb_sdram_arbiter;
  localparam int AW = 25;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    p_valid;
  logic [AW-1:0] p_addr [2];
  logic [31:0]   p_wdata [2];
  logic [3:0]    p_wstrb [2];
  logic          p0_ready, p1_ready;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          sd_valid, sd_ready;
  logic [AW-1:0] sd_addr;
  logic [31:0]   sd_din, sd_dout;
  logic [3:0]    sd_wmask;

  sdram_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(p_valid[0]), .p0_addr(p_addr[0]), .p0_wdata(p_wdata[0]), .p0_wstrb(p_wstrb[0]),
    .p0_ready(p0_ready), .p0_rdata(p0_rdata),
    .p1_valid(p_valid[1]), .p1_addr(p_addr[1]), .p1_wdata(p_wdata[1]), .p1_wstrb(p_wstrb[1]),
    .p1_ready(p1_ready), .p1_rdata(p1_rdata),
    .sd_valid(sd_valid), .sd_addr(sd_addr), .sd_din(sd_din), .sd_wmask(sd_wmask),
    .sd_ready(sd_ready), .sd_dout(sd_dout)
  );

  logic          f_resetn = 1'b0, f_p0_valid = 1'b0, f_p1_valid = 1'b0, f_sd_ready = 1'b0;
  logic          f_p0_ready, f_p1_ready, f_sd_valid;
  logic [31:0]   f_p0_rdata, f_p1_rdata, f_sd_din;
  logic [AW-1:0] f_sd_addr;
  logic [3:0]    f_sd_wmask;

  sdram_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b1)) dut_fixed (
    .clk(clk), .resetn(f_resetn),
    .p0_valid(f_p0_valid), .p0_addr(AW'(0)), .p0_wdata(32'h0), .p0_wstrb(4'h1),
    .p0_ready(f_p0_ready), .p0_rdata(f_p0_rdata),
    .p1_valid(f_p1_valid), .p1_addr(AW'(0)), .p1_wdata(32'h0), .p1_wstrb(4'h2),
    .p1_ready(f_p1_ready), .p1_rdata(f_p1_rdata),
    .sd_valid(f_sd_valid), .sd_addr(f_sd_addr), .sd_din(f_sd_din), .sd_wmask(f_sd_wmask),
    .sd_ready(f_sd_ready), .sd_dout(32'h0)
  );

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // controller model: answers after a random delay and holds sd_ready for a random time
  logic ctl_en = 1'b0, fix_en = 1'b0;
  logic [31:0] fix_dout = 32'h0;
  int ph = 0, cnt = 0;
  initial forever begin
    @(negedge clk);
    if (ctl_en) begin
      if (!resetn) begin
        ph = 0;
        sd_ready = 1'b0;
      end else if (ph == 0) begin
        if (sd_valid) begin ph = 1; cnt = $urandom_range(3, 0); end
      end else if (ph == 1) begin
        if (cnt == 0) begin
          sd_ready = 1'b1;
          sd_dout = fix_en ? fix_dout : $urandom;
          cnt = $urandom_range(5, 0);
          ph = 2;
        end else cnt--;
      end else begin
        if (cnt == 0) begin sd_ready = 1'b0; ph = 0; end else cnt--;
      end
    end
  end

  // port drivers: hold a request until ready, then drop it or present a fresh one
  logic [1:0] gen_en = 2'b00;
  logic renew_all = 1'b0;
  task automatic new_req(input int i);
    p_addr[i]  = AW'($urandom);
    p_wdata[i] = $urandom;
    p_wstrb[i] = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom_range(15, 1));
    p_valid[i] = 1'b1;
  endtask
  task automatic drv(input int i);
    forever begin
      @(negedge clk);
      if (p_valid[i]) begin
        if (i == 1 ? p1_ready : p0_ready) begin
          if (gen_en[i] && (renew_all || $urandom_range(1, 0) == 1)) new_req(i);
          else p_valid[i] = 1'b0;
        end
      end else if (gen_en[i] && $urandom_range(3, 0) == 0) new_req(i);
    end
  endtask
  initial drv(0);
  initial drv(1);

  // reference model + scoreboard: grants predicted from the arbitration rules, completions queued
  logic last_m = 1'b1, prev_v = 1'b0, prev_rdy = 1'b0, mw, mrd;
  logic [31:0] m_rd [2];
  logic pend_w[$], pend_rd[$], done_w[$];
  initial begin
    m_rd[0] = 32'h0;
    m_rd[1] = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        chk("reset_outputs", {sd_valid, sd_wmask, sd_addr, sd_din, p0_ready, p1_ready}, 64'h0);
        chk("reset_rdata", {p0_rdata, p1_rdata}, 64'h0);
        m_rd[0] = 32'h0;
        m_rd[1] = 32'h0;
        last_m = 1'b1;
        prev_v = 1'b0;
        prev_rdy = 1'b0;
        pend_w.delete();
        pend_rd.delete();
        done_w.delete();
      end else begin
        if (sd_valid && !prev_v) begin
          mw = (p_valid == 2'b11) ? ~last_m : p_valid[1];
          chk("grant_has_request", p_valid != 2'b00, 1);
          chk("grant_sd_ready_low", sd_ready, 0);
          chk("sd_addr", sd_addr, p_addr[mw] & ~AW'(3));
          chk("sd_din", sd_din, p_wdata[mw]);
          chk("sd_wmask", sd_wmask, p_wstrb[mw]);
          last_m = mw;
          pend_w.push_back(mw);
          pend_rd.push_back(p_wstrb[mw] == 4'h0);
        end
        if (!sd_valid && prev_v) begin
          chk("capture_expected", pend_w.size() != 0, 1);
          if (pend_w.size() != 0) begin
            mw = pend_w.pop_front();
            mrd = pend_rd.pop_front();
            if (mrd) m_rd[mw] = sd_dout;
            done_w.push_back(mw);
          end
          chk("wmask_cleared", sd_wmask, 0);
        end
        if (p0_ready || p1_ready) begin
          chk("ready_onehot", p0_ready && p1_ready, 0);
          chk("ready_single_pulse", prev_rdy, 0);
          chk("ready_after_sd_release", sd_ready, 0);
          chk("ready_expected", done_w.size() != 0, 1);
          if (done_w.size() != 0) chk("ready_port", p1_ready, done_w.pop_front());
          chk("p0_rdata", p0_rdata, m_rd[0]);
          chk("p1_rdata", p1_rdata, m_rd[1]);
        end
        prev_rdy = p0_ready || p1_ready;
        prev_v = sd_valid;
      end
    end
  end

  // fixed-priority instance: single-cycle controller, grant order checked against a queue
  logic f_exp[$];
  initial forever begin
    @(negedge clk);
    if (f_sd_valid && !f_sd_ready) begin
      chk("f_grant_expected", f_exp.size() != 0, 1);
      if (f_exp.size() != 0) chk("f_grant_port", f_sd_wmask, f_exp.pop_front() ? 4'h2 : 4'h1);
      f_sd_ready = 1'b1;
    end else if (f_sd_ready && !f_sd_valid) f_sd_ready = 1'b0;
  end

  task automatic wait_rdy(input int i, input int lim);
    int k = 0;
    while (!(i == 1 ? p1_ready : p0_ready) && k < lim) begin @(negedge clk); k++; end
    chk("ready_timeout", k < lim, 1);
  endtask
  task automatic wait_sdv(input int lim);
    int k = 0;
    while (!sd_valid && k < lim) begin @(negedge clk); k++; end
    chk("sd_valid_timeout", k < lim, 1);
  endtask

  initial begin
    p_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      p_addr[i] = '0;
      p_wdata[i] = '0;
      p_wstrb[i] = '0;
    end
    sd_ready = 1'b1;
    sd_dout = 32'h0;
    repeat (3) @(negedge clk);
    p_addr[0] = AW'(32'h104);
    p_wstrb[0] = 4'h0;
    p_valid[0] = 1'b1;
    fix_dout = 32'hDEADBEEF;
    fix_en = 1'b1;
    resetn = 1'b1;
    repeat (5) begin @(negedge clk); chk("hold_while_sd_ready", sd_valid, 0); end
    sd_ready = 1'b0;
    ctl_en = 1'b1;
    wait_rdy(0, 100);
    chk("p0_rdata_deadbeef", p0_rdata, 32'hDEADBEEF);
    fix_en = 1'b0;
    @(negedge clk);
    p_addr[1] = AW'(32'h207);
    p_wdata[1] = 32'h12345678;
    p_wstrb[1] = 4'b0011;
    p_valid[1] = 1'b1;
    wait_sdv(50);
    chk("p1_sd_addr", sd_addr, 25'h204);
    chk("p1_sd_din", sd_din, 32'h12345678);
    chk("p1_sd_wmask", sd_wmask, 4'b0011);
    wait_rdy(1, 100);
    chk("p1_rdata_after_write", p1_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p_addr[i] = AW'($urandom);
      p_wdata[i] = $urandom;
    end
    p_wstrb[0] = 4'hF;
    p_wstrb[1] = 4'h5;
    p_valid = 2'b11;
    renew_all = 1'b1;
    gen_en = 2'b11;
    begin
      int c = 0, k = 0;
      while (c < 8 && k < 400) begin @(negedge clk); k++; if (p0_ready || p1_ready) c++; end
      chk("back_to_back_pairs", c, 8);
    end
    renew_all = 1'b0;
    repeat (2000) @(negedge clk);
    gen_en = 2'b00;
    begin
      int k = 0;
      while (p_valid != 2'b00 && k < 500) begin @(negedge clk); k++; end
      chk("ports_idle", p_valid, 2'b00);
    end
    new_req(0);
    p_wstrb[0] = 4'h0;
    wait_sdv(50);
    resetn = 1'b0;
    @(negedge clk);
    chk("no_ready_in_reset", {p0_ready, p1_ready}, 2'b00);
    chk("sd_valid_reset", sd_valid, 0);
    @(negedge clk);
    resetn = 1'b1;
    wait_rdy(0, 100);
    begin
      int k = 0;
      while ((p_valid != 2'b00 || sd_valid || pend_w.size() != 0 || done_w.size() != 0) && k < 500) begin
        @(negedge clk);
        k++;
      end
      chk("drain", k < 500, 1);
    end
    f_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    repeat (2) @(negedge clk);
    f_resetn = 1'b1;
    f_p0_valid = 1'b1;
    f_p1_valid = 1'b1;
    begin
      int c = 0, k = 0;
      while (c < 4 && k < 300) begin
        @(negedge clk);
        k++;
        if (f_p0_ready) c++;
        chk("f_p1_starved", f_p1_ready, 0);
      end
      chk("f_p0_grants", c, 4);
    end
    f_p0_valid = 1'b0;
    begin
      int k = 0;
      while (!f_p1_ready && k < 100) begin @(negedge clk); k++; end
      chk("f_p1_served", f_p1_ready, 1);
    end
    f_p1_valid = 1'b0;
    chk("f_grants_drained", f_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end
endmodule
